// File: rtl/carrier_loop_nco_pkg.sv
// Shared carrier-loop definitions: widths, lock-state encodings and error magnitude.
package carrier_loop_nco_pkg;

    localparam int unsigned FREQ_WIDTH = 32;
    localparam int unsigned LAG_WIDTH  = 40;

    // One-hot lock state encodings
    localparam logic [1:0] LOCK_UNLOCKED = 2'b01;
    localparam logic [1:0] LOCK_LOCKED   = 2'b10;

    // |e| for an 8-bit two's-complement error; -128 folds to 127 so the result fits 7 bits.
    function automatic logic [6:0] err_mag(input logic [7:0] e);
        logic [7:0] neg;
        neg = 8'd0 - e;
        if (e == 8'h80) begin
            return 7'h7f;
        end else if (e[7]) begin
            return neg[6:0];
        end else begin
            return e[6:0];
        end
    endfunction

endpackage

// File: rtl/carrier_loop_nco_if.sv
// Sample-stream bus between the loop filter (master) and the NCO/lock block (slave).
interface carrier_loop_nco_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    import carrier_loop_nco_pkg::*;

    logic                   clkEn;
    logic [7:0]             error;
    logic [4:0]             leadExp;
    logic [LAG_WIDTH-1:0]   lagAccum;
    logic [FREQ_WIDTH-1:0]  centerFreq;
    logic [6:0]             lockThreshold;
    logic [CNT_WIDTH-1:0]   lockCount;
    logic [CNT_WIDTH-1:0]   unlockCount;
    logic                   phaseReset;
    logic [FREQ_WIDTH-1:0]  freq;
    logic [FREQ_WIDTH-1:0]  phase;
    logic                   carrierInSync;

    modport master (
        output clkEn, error, leadExp, lagAccum, centerFreq,
        output lockThreshold, lockCount, unlockCount, phaseReset,
        input  freq, phase, carrierInSync
    );

    modport slave (
        input  clkEn, error, leadExp, lagAccum, centerFreq,
        input  lockThreshold, lockCount, unlockCount, phaseReset,
        output freq, phase, carrierInSync
    );

endinterface

// File: rtl/carrier_lock_detect.sv
// Carrier lock detector: counts consecutive good/bad error samples and drives carrierInSync.
module carrier_lock_detect
    import carrier_loop_nco_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en_i,
    input  logic [7:0]           error_i,
    input  logic [6:0]           lock_threshold_i,
    input  logic [CNT_WIDTH-1:0] lock_count_i,
    input  logic [CNT_WIDTH-1:0] unlock_count_i,
    output logic                 carrier_in_sync_o
);

    logic [1:0]           state_q, state_d;
    logic                 sync_q, sync_d;
    logic [CNT_WIDTH-1:0] good_q, good_d;
    logic [CNT_WIDTH-1:0] bad_q, bad_d;

    logic                 good_smp;
    logic [CNT_WIDTH-1:0] good_inc, bad_inc;
    logic [CNT_WIDTH-1:0] lock_min, unlock_min;

    // Sample qualification and saturating increments
    always_comb begin
        good_smp   = err_mag(error_i) < lock_threshold_i;
        good_inc   = (&good_q) ? good_q : good_q + 1'b1;
        bad_inc    = (&bad_q) ? bad_q : bad_q + 1'b1;
        lock_min   = (lock_count_i == '0) ? CNT_WIDTH'(1) : lock_count_i;
        unlock_min = (unlock_count_i == '0) ? CNT_WIDTH'(1) : unlock_count_i;
    end

    // Lock FSM next state; only advances on enabled samples
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (clk_en_i) begin
            case (state_q)
                LOCK_UNLOCKED: begin
                    if (!good_smp) begin
                        good_d = '0;
                    end else if (good_inc >= lock_min) begin
                        state_d = LOCK_LOCKED;
                        sync_d  = 1'b1;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end
                LOCK_LOCKED: begin
                    if (good_smp) begin
                        bad_d = '0;
                    end else if (bad_inc >= unlock_min) begin
                        state_d = LOCK_UNLOCKED;
                        sync_d  = 1'b0;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_inc;
                    end
                end
                default: begin
                    state_d = LOCK_UNLOCKED;
                    sync_d  = 1'b0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // Lock state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOCK_UNLOCKED;
            sync_q  <= 1'b0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    assign carrier_in_sync_o = sync_q;

endmodule

// File: rtl/carrier_loop_nco.sv
// Carrier loop back end: lead path, frequency word summation, NCO phase and lock detect.
module carrier_loop_nco
    import carrier_loop_nco_pkg::*;
#(
    parameter int unsigned MAX_LEAD_SHIFT = 24,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic               clk,
    input  logic               reset,
    carrier_loop_nco_if.slave  bus
);

    logic [FREQ_WIDTH-1:0] lead_q, lead_d;
    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic [FREQ_WIDTH-1:0] phase_q, phase_d;
    logic [4:0]            lead_sh;
    logic [4:0]            lead_exp_m1;
    logic                  unused_lag;

    // Only the integer part of the lag accumulator feeds the frequency word
    assign unused_lag = ^bus.lagAccum[7:0];

    // Lead shifter: shift of leadExp-1, clamped at MAX_LEAD_SHIFT
    always_comb begin
        lead_exp_m1 = bus.leadExp - 5'd1;
        if (lead_exp_m1 > 5'(MAX_LEAD_SHIFT)) begin
            lead_sh = 5'(MAX_LEAD_SHIFT);
        end else begin
            lead_sh = lead_exp_m1;
        end
        if (bus.leadExp == 5'd0) begin
            lead_d = '0;
        end else begin
            lead_d = {{(FREQ_WIDTH-8){bus.error[7]}}, bus.error} << lead_sh;
        end
    end

    // Frequency word and phase integration; all sums wrap modulo 2^32
    always_comb begin
        freq_d  = bus.centerFreq + bus.lagAccum[LAG_WIDTH-1:8] + lead_q;
        phase_d = phase_q + freq_q;
    end

    // Pipeline registers; phaseReset clears phase even with clkEn low
    always_ff @(posedge clk) begin
        if (reset) begin
            lead_q  <= '0;
            freq_q  <= '0;
            phase_q <= '0;
        end else begin
            if (bus.clkEn) begin
                lead_q <= lead_d;
                freq_q <= freq_d;
            end
            if (bus.phaseReset) begin
                phase_q <= '0;
            end else if (bus.clkEn) begin
                phase_q <= phase_d;
            end
        end
    end

    assign bus.freq  = freq_q;
    assign bus.phase = phase_q;

    carrier_lock_detect #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lock (
        .clk               (clk),
        .reset             (reset),
        .clk_en_i          (bus.clkEn),
        .error_i           (bus.error),
        .lock_threshold_i  (bus.lockThreshold),
        .lock_count_i      (bus.lockCount),
        .unlock_count_i    (bus.unlockCount),
        .carrier_in_sync_o (bus.carrierInSync)
    );

endmodule

// File: tb/tb_carrier_loop_nco.sv
// Directed bench for carrier_loop_nco with hand-computed expectations.
module tb_carrier_loop_nco;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    carrier_loop_nco_if #(.CNT_WIDTH(16)) bus ();

    carrier_loop_nco #(
        .MAX_LEAD_SHIFT (24),
        .CNT_WIDTH      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; outputs are then stable 1 time unit after the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One enabled sample with the given error
    task automatic feed(input logic [7:0] e);
        bus.error = e;
        step(1);
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        reset             = 1'b1;
        bus.clkEn         = 1'b1;
        bus.error         = 8'd0;
        bus.leadExp       = 5'd0;
        bus.lagAccum      = 40'd0;
        bus.centerFreq    = 32'd0;
        bus.lockThreshold = 7'd0;
        bus.lockCount     = 16'd4;
        bus.unlockCount   = 16'd3;
        bus.phaseReset    = 1'b0;

        // Reset state
        step(2);
        check("rst_freq", bus.freq, 32'h0);
        check("rst_phase", bus.phase, 32'h0);
        check("rst_sync", {31'd0, bus.carrierInSync}, 32'h0);
        reset = 1'b0;

        // Phase ramp from center frequency only
        bus.centerFreq = 32'h0100_0000;
        step(2);
        check("ramp_freq", bus.freq, 32'h0100_0000);
        check("ramp_phase1", bus.phase, 32'h0100_0000);
        step(1);
        check("ramp_phase2", bus.phase, 32'h0200_0000);
        step(254);
        check("ramp_wrap", bus.phase, 32'h0);
        check("thr0_nolock", {31'd0, bus.carrierInSync}, 32'h0);

        // Lead path: -3 unshifted plus lag integer 10
        bus.leadExp    = 5'd1;
        bus.error      = 8'hFD;
        bus.lagAccum   = 40'h00_0000_0A00;
        bus.centerFreq = 32'h0;
        step(2);
        check("lead_exp1", bus.freq, 32'h0000_0007);
        bus.leadExp = 5'd31;
        step(2);
        check("lead_sat", bus.freq, 32'hFD00_000A);

        // Frequency wrap and phase wrap via 0xFFFFFFFF
        bus.leadExp    = 5'd0;
        bus.error      = 8'd0;
        bus.lagAccum   = 40'd0;
        bus.centerFreq = 32'hFFFF_FFFF;
        step(2);
        check("freq_ff", bus.freq, 32'hFFFF_FFFF);
        bus.clkEn      = 1'b0;
        bus.phaseReset = 1'b1;
        step(1);
        check("prst_noen", bus.phase, 32'h0);
        check("prst_freq_hold", bus.freq, 32'hFFFF_FFFF);
        bus.phaseReset = 1'b0;
        bus.clkEn      = 1'b1;
        bus.lagAccum   = 40'h00_0000_0200;
        step(1);
        check("phase_ff", bus.phase, 32'hFFFF_FFFF);
        check("freq_wrap", bus.freq, 32'h0000_0001);
        step(1);
        check("phase_wrap", bus.phase, 32'h0);

        // clkEn low holds freq and phase
        bus.clkEn      = 1'b0;
        bus.centerFreq = 32'h1234_5678;
        step(3);
        check("hold_freq", bus.freq, 32'h0000_0001);
        check("hold_phase", bus.phase, 32'h0);
        bus.centerFreq = 32'hFFFF_FFFF;
        bus.clkEn      = 1'b1;
        step(1);
        check("phase_one", bus.phase, 32'h0000_0001);
        bus.phaseReset = 1'b1;
        step(1);
        check("prst_prio", bus.phase, 32'h0);
        bus.phaseReset = 1'b0;

        // Lock detector
        bus.lockThreshold = 7'd8;
        feed(8'd2);
        feed(8'd5);
        feed(8'hF9);
        check("lock_pre", {31'd0, bus.carrierInSync}, 32'h0);
        feed(8'd3);
        check("lock_4th", {31'd0, bus.carrierInSync}, 32'h1);

        feed(8'd20);
        feed(8'h80);
        check("unlock_pre", {31'd0, bus.carrierInSync}, 32'h1);
        feed(8'd30);
        check("unlock_3rd", {31'd0, bus.carrierInSync}, 32'h0);

        feed(8'd2);
        feed(8'd9);
        feed(8'd2);
        feed(8'd2);
        feed(8'd2);
        check("relock_pre", {31'd0, bus.carrierInSync}, 32'h0);
        feed(8'd2);
        check("relock", {31'd0, bus.carrierInSync}, 32'h1);

        feed(8'd20);
        feed(8'd1);
        feed(8'd20);
        feed(8'd20);
        check("stay_locked", {31'd0, bus.carrierInSync}, 32'h1);

        // phaseReset leaves lock state alone
        bus.clkEn      = 1'b0;
        bus.phaseReset = 1'b1;
        step(1);
        check("prst_lock", {31'd0, bus.carrierInSync}, 32'h1);
        bus.phaseReset = 1'b0;
        bus.clkEn      = 1'b1;

        // Mid-operation reset while locked with badCnt nonzero
        feed(8'd2);
        feed(8'd20);
        reset = 1'b1;
        step(1);
        check("mrst_freq", bus.freq, 32'h0);
        check("mrst_phase", bus.phase, 32'h0);
        check("mrst_sync", {31'd0, bus.carrierInSync}, 32'h0);
        reset = 1'b0;
        feed(8'd1);
        feed(8'd1);
        feed(8'd1);
        check("mrst_relock_pre", {31'd0, bus.carrierInSync}, 32'h0);
        feed(8'd1);
        check("mrst_relock", {31'd0, bus.carrierInSync}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
